// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with independent TX and RX
// baud timers, a 2-flop RX synchroniser and a mid-bit-sampled receiver.
//
// Optional feature: define UART_LOOPBACK_EN to add the 'loopback' input.
// When it is set, the receiver listens to the internal tx line instead of the
// rx pin. The select is only updated while the RX FSM is idle.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   loopback       (UART_LOOPBACK_EN only) route tx into the receiver
//   tx_start       request to send tx_data; ignored while tx_busy
//   tx_data        word to transmit, latched on acceptance
//   tx             serial output, idles high
//   tx_busy        transmitter not idle
//   tx_done        one-cycle pulse as the TX FSM re-enters idle
//   rx             asynchronous serial input
//   rx_data        last received word
//   rx_valid       one-cycle pulse, new word on rx_data
//   rx_parity_err  parity mismatch on last word (always 0 without parity)
//   rx_frame_err   first stop bit sampled low on last word
//
// States (shared encoding, S_BREAK used by RX only):
//   state    | meaning
//   S_IDLE   | line idle, counter preloaded
//   S_START  | start bit (RX: half-bit wait, then false-start check)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when PARITY != 0)
//   S_STOP   | stop bit(s); RX checks only the first
//   S_BREAK  | RX after a framing error, waits for line high

module uart_core #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int              DIV         = CLK_FREQ / BAUD;
    localparam int              CW          = $clog2(DIV);
    localparam logic [CW-1:0]   BIT_RELOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_RELOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [3:0]      DATA_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST   = 4'(STOP_BITS - 1);
    localparam logic            HAS_PARITY  = (PARITY != 0);
    localparam logic            ODD_PARITY  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t                tx_state, tx_next;
    logic [CW-1:0]         tx_cnt;
    logic [3:0]            tx_idx;
    logic [DATA_BITS-1:0]  tx_shift;
    logic                  tx_par;
    logic                  tx_tc;
    logic                  tx_last_stop;

    assign tx_tc        = (tx_cnt == '0);
    assign tx_last_stop = (tx_state == S_STOP) && tx_tc && (tx_idx == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_start) tx_next = S_START;
            S_START:  if (tx_tc) tx_next = S_DATA;
            S_DATA:   if (tx_tc && tx_idx == DATA_LAST)
                          tx_next = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (tx_tc) tx_next = S_STOP;
            S_STOP:   if (tx_last_stop) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_busy = (tx_state != S_IDLE);
        case (tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift[0];
            S_PARITY: tx = tx_par;
            default:  tx = 1'b1;
        endcase
    end

    // Counter is preloaded in idle so the start bit gets a full DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= tx_last_stop;
            if (tx_state == S_IDLE) begin
                tx_cnt <= BIT_RELOAD;
                tx_idx <= '0;
                if (tx_start) begin
                    tx_shift <= tx_data;
                    tx_par   <= (^tx_data) ^ ODD_PARITY;
                end
            end else begin
                tx_cnt <= tx_tc ? BIT_RELOAD : tx_cnt - CNT_ONE;
                if (tx_tc) begin
                    case (tx_state)
                        S_DATA: begin
                            tx_shift <= tx_shift >> 1;
                            // Clear on the last data bit so STOP counts from 0.
                            tx_idx   <= (tx_idx == DATA_LAST) ? 4'd0 : tx_idx + 4'd1;
                        end
                        S_STOP:  tx_idx <= tx_idx + 4'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t                rx_state, rx_next;
    logic                  rx_src, rx_meta, rx_sync;
    logic [CW-1:0]         rx_cnt;
    logic [3:0]            rx_idx;
    logic [DATA_BITS-1:0]  rx_shift;
    logic                  rx_par_bit;
    logic                  rx_tc;
    logic                  rx_counting;
    logic                  rx_take_data, rx_take_par, rx_take_stop;

`ifdef UART_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge clk) begin
        if (rst)                    lb_q <= 1'b0;
        else if (rx_state == S_IDLE) lb_q <= loopback;
    end

    assign rx_src = lb_q ? tx : rx;
`else
    assign rx_src = rx;
`endif

    // Resets to the idle level so reset release cannot look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    assign rx_tc = (rx_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (!rx_sync) rx_next = S_START;
            S_START:  if (rx_tc) rx_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (rx_tc && rx_idx == DATA_LAST)
                          rx_next = HAS_PARITY ? S_PARITY : S_STOP;
            S_PARITY: if (rx_tc) rx_next = S_STOP;
            S_STOP:   if (rx_tc) rx_next = rx_sync ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_sync) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_counting  = (rx_state != S_IDLE) && (rx_state != S_BREAK);
        rx_take_data = (rx_state == S_DATA)   && rx_tc;
        rx_take_par  = (rx_state == S_PARITY) && rx_tc;
        rx_take_stop = (rx_state == S_STOP)   && rx_tc;
    end

    // Idle preloads a half bit so the first sample lands mid start bit;
    // every later sample is a full bit further on.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= rx_take_stop;
            if (!rx_counting) begin
                rx_cnt <= HALF_RELOAD;
                rx_idx <= '0;
            end else begin
                rx_cnt <= rx_tc ? BIT_RELOAD : rx_cnt - CNT_ONE;
            end
            if (rx_take_data) begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + 4'd1;
            end
            if (rx_take_par) rx_par_bit <= rx_sync;
            if (rx_take_stop) begin
                rx_data       <= rx_shift;
                rx_parity_err <= HAS_PARITY && (rx_par_bit != ((^rx_shift) ^ ODD_PARITY));
                rx_frame_err  <= ~rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

    localparam int CF = 1_000_000;
    localparam int BR = 100_000;   // DIV = 10

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: 8N1, bench drives rx
    logic       tx_start_a, tx_a, tx_busy_a, tx_done_a, rx_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       rx_valid_a, rx_perr_a, rx_ferr_a;
    // Instance B: even parity, 2 stop bits, tx wired to rx
    logic       tx_start_b, tx_b, tx_busy_b, tx_done_b;
    logic [7:0] tx_data_b, rx_data_b;
    logic       rx_valid_b, rx_perr_b, rx_ferr_b;
    // Instance C: odd parity, 1 stop bit, bench drives rx
    logic       tx_start_c, tx_c, tx_busy_c, tx_done_c, rx_c;
    logic [7:0] tx_data_c, rx_data_c;
    logic       rx_valid_c, rx_perr_c, rx_ferr_c;

    int total = 0;
    int bad   = 0;
    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
    int base;

    uart_core #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .tx_start(tx_start_a), .tx_data(tx_data_a), .tx(tx_a), .tx_busy(tx_busy_a),
        .tx_done(tx_done_a), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a));

    uart_core #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .tx_start(tx_start_b), .tx_data(tx_data_b), .tx(tx_b), .tx_busy(tx_busy_b),
        .tx_done(tx_done_b), .rx(tx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b));

    uart_core #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .tx_start(tx_start_c), .tx_data(tx_data_c), .tx(tx_c), .tx_busy(tx_busy_c),
        .tx_done(tx_done_c), .rx(rx_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
        .rx_parity_err(rx_perr_c), .rx_frame_err(rx_ferr_c));

    always @(negedge clk) begin
        if (rx_valid_a) vcnt_a++;
        if (rx_valid_b) vcnt_b++;
        if (rx_valid_c) vcnt_c++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line level c cycles into a frame (c=1 is the first start-bit cycle).
    function automatic logic fbit(input int c, input logic [7:0] d, input int par);
        int idx;
        idx = (c - 1) / 10;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (par != 0 && idx == 9) return (par == 2) ? ^d : ~^d;
        return 1'b1;
    endfunction

    // {tx, tx_busy, tx_done} of instance A (0) or B (1)
    function automatic logic [2:0] tx_outs(input int inst);
        return (inst == 0) ? {tx_a, tx_busy_a, tx_done_a} : {tx_b, tx_busy_b, tx_done_b};
    endfunction

    task automatic tx_frame(input int inst, input logic [7:0] d, input int par,
                            input int stops, input bit poke);
        int len;
        logic [2:0] o;
        len = (9 + ((par != 0) ? 1 : 0) + stops) * 10;
        if (inst == 0) begin tx_data_a = d; tx_start_a = 1'b1; end
        else           begin tx_data_b = d; tx_start_b = 1'b1; end
        tick(1);
        tx_start_a = 1'b0;
        tx_start_b = 1'b0;
        for (int c = 1; c <= len; c++) begin
            o = tx_outs(inst);
            chk("tx_line", {31'd0, o[2]}, {31'd0, fbit(c, d, par)});
            chk("tx_busy_in_frame", {31'd0, o[1]}, 32'd1);
            chk("tx_done_early", {31'd0, o[0]}, 32'd0);
            // a second request mid-frame must be ignored
            if (poke && c == 50) begin tx_data_a = ~d; tx_start_a = 1'b1; end
            if (poke && c == 51) tx_start_a = 1'b0;
            tick(1);
        end
        o = tx_outs(inst);
        chk("tx_done_pulse", {29'd0, o}, {29'd0, 3'b101});
        tick(1);
        o = tx_outs(inst);
        chk("tx_after_done", {29'd0, o}, {29'd0, 3'b100});
    endtask

    // Drive n bit-times on rx of A (0) or C (1), LSB of bits first.
    // The line is left at the last bit's level.
    task automatic rx_send(input int inst, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst == 0) rx_a = bits[i];
            else           rx_c = bits[i];
            tick(10);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_start_a = 1'b0; tx_data_a = 8'h00; rx_a = 1'b1;
        tx_start_b = 1'b0; tx_data_b = 8'h00;
        tx_start_c = 1'b0; tx_data_c = 8'h00; rx_c = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // reset state
        chk("rst_tx_a", {29'd0, tx_a, tx_busy_a, tx_done_a}, {29'd0, 3'b100});
        chk("rst_tx_b", {29'd0, tx_b, tx_busy_b, tx_done_b}, {29'd0, 3'b100});
        chk("rst_tx_c", {29'd0, tx_c, tx_busy_c, tx_done_c}, {29'd0, 3'b100});
        chk("rst_rx_a", {21'd0, rx_data_a, rx_valid_a, rx_perr_a, rx_ferr_a}, 32'd0);
        chk("rst_rx_b", {21'd0, rx_data_b, rx_valid_b, rx_perr_b, rx_ferr_b}, 32'd0);
        chk("rst_rx_c", {21'd0, rx_data_c, rx_valid_c, rx_perr_c, rx_ferr_c}, 32'd0);

        // Test 1: 8N1 transmit of 0xA5 with a mid-frame request
        tx_frame(0, 8'hA5, 0, 1, 1'b1);

        // Test 2: even parity, two stop bits, looped into its own receiver.
        // 0x3C has four ones -> parity bit 0; frame is 12 bit times = 120 cycles.
        base = vcnt_b;
        tx_frame(1, 8'h3C, 2, 2, 1'b0);
        tick(5);
        chk("t2_valid_count", vcnt_b - base, 32'd1);
        chk("t2_rx_data", {24'd0, rx_data_b}, 32'h3C);
        chk("t2_errs", {30'd0, rx_perr_b, rx_ferr_b}, 32'd0);

        // Test 3: odd parity; 0x01 needs parity 0, send 1
        base = vcnt_c;
        rx_send(1, {5'd0, 1'b1, 1'b1, 8'h01, 1'b0}, 11);
        tick(5);
        chk("t3_valid_count", vcnt_c - base, 32'd1);
        chk("t3_rx_data", {24'd0, rx_data_c}, 32'h01);
        chk("t3_perr_set", {30'd0, rx_perr_c, rx_ferr_c}, 32'b10);
        // 0x03 with correct odd parity bit 1 clears the flag
        rx_send(1, {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        tick(5);
        chk("t3_valid_count2", vcnt_c - base, 32'd2);
        chk("t3_rx_data2", {24'd0, rx_data_c}, 32'h03);
        chk("t3_perr_clear", {30'd0, rx_perr_c, rx_ferr_c}, 32'b00);

        // Test 4: 0x55 with low stop bit, then a held-low line
        base = vcnt_a;
        rx_send(0, {6'd0, 1'b0, 8'h55, 1'b0}, 10);
        tick(50);
        chk("t4_valid_count", vcnt_a - base, 32'd1);
        chk("t4_rx_data", {24'd0, rx_data_a}, 32'h55);
        chk("t4_ferr", {30'd0, rx_perr_a, rx_ferr_a}, 32'b01);
        tick(100);
        chk("t4_no_retrigger", vcnt_a - base, 32'd1);
        rx_a = 1'b1;
        tick(20);
        chk("t4_line_high", vcnt_a - base, 32'd1);

        // Test 5: 3-cycle glitch is not a start bit; flags hold
        rx_a = 1'b0;
        tick(3);
        rx_a = 1'b1;
        tick(30);
        chk("t5_no_valid", vcnt_a - base, 32'd1);
        chk("t5_data_held", {24'd0, rx_data_a}, 32'h55);
        chk("t5_flags_held", {30'd0, rx_perr_a, rx_ferr_a}, 32'b01);

        // a good frame after the break is received and clears the flag
        rx_send(0, {6'd0, 1'b1, 8'h0F, 1'b0}, 10);
        tick(5);
        chk("t4_new_frame", vcnt_a - base, 32'd2);
        chk("t4_new_data", {24'd0, rx_data_a}, 32'h0F);
        chk("t4_ferr_clear", {30'd0, rx_perr_a, rx_ferr_a}, 32'b00);

        // Test 6: reset during data bit 3 of 0xFF
        tx_data_a = 8'hFF;
        tx_start_a = 1'b1;
        tick(1);
        tx_start_a = 1'b0;
        tick(44);
        chk("t6_mid_bit3", {30'd0, tx_a, tx_busy_a}, 32'b11);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_after_rst", {29'd0, tx_a, tx_busy_a, tx_done_a}, {29'd0, 3'b100});
        chk("t6_rx_cleared", {24'd0, rx_data_a}, 32'h00);
        tick(2);
        tx_frame(0, 8'hFF, 0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
